// File: rtl/tcp_event_arbiter.sv
// Round-robin arbiter that shares one TCP connection-FSM engine between NUM_REQ event sources.
// Optional feature macro: RST_PRIO_EN (events flagged with RST win over round-robin order).
module tcp_event_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  input  logic [NUM_REQ-1:0]          req_rst,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        eng_valid,
  output logic [DATA_W-1:0]           eng_data,
  output logic [$clog2(NUM_REQ)-1:0]  eng_src,
  input  logic                        eng_ready,
  input  logic                        eng_done,
  output logic                        busy,
  output logic                        timeout_err
);

  localparam int SRC_W = $clog2(NUM_REQ);
  localparam int WD_W  = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DONE
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [SRC_W-1:0]   r_rr_ptr;
  logic [SRC_W-1:0]   r_eng_src;
  logic [DATA_W-1:0]  r_eng_data;
  logic [WD_W-1:0]    r_wd_cnt;
  logic               r_timeout_err;

  logic [NUM_REQ-1:0] w_cand;
  logic [SRC_W-1:0]   w_idx;
  logic [SRC_W-1:0]   w_pick;
  logic               w_any;
  logic               w_wd_exp;
  logic [SRC_W-1:0]   w_src_next;
  logic [NUM_REQ-1:0] w_req_ready;

`ifdef RST_PRIO_EN
  // RST-flagged events pre-empt the round-robin order; round-robin still breaks ties among them.
  always_comb begin
    w_cand = req_valid;
    if (|(req_valid & req_rst)) w_cand = req_valid & req_rst;
  end
`else
  logic w_unused_req_rst;
  assign w_unused_req_rst = ^req_rst;
  assign w_cand           = req_valid;
`endif

  // Scan from the highest offset down so the last hit is the one closest to r_rr_ptr.
  // NOTE: every variable written in always_comb gets a default first, so no latch is inferred.
  always_comb begin
    w_any  = 1'b0;
    w_pick = '0;
    w_idx  = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = SRC_W'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (w_cand[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  assign w_wd_exp   = (r_wd_cnt == WD_W'(TIMEOUT_CYC - 1));
  assign w_src_next = (r_eng_src == SRC_W'(NUM_REQ - 1)) ? '0 : r_eng_src + 1'b1;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:      if (w_any)                 w_state_nxt = S_ISSUE;
      S_ISSUE:     if (eng_ready)             w_state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: if (eng_done || w_wd_exp)  w_state_nxt = S_IDLE;
      default:                                w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= '0;
      r_eng_src     <= '0;
      r_eng_data    <= '0;
      r_wd_cnt      <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_timeout_err <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_eng_src  <= w_pick;
            r_eng_data <= req_data[w_pick*DATA_W +: DATA_W];
          end
        end
        S_ISSUE: begin
          if (eng_ready) r_wd_cnt <= '0;
        end
        S_WAIT_DONE: begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
          if (eng_done || w_wd_exp) r_rr_ptr <= w_src_next;
          // Completion in the expiry cycle counts as a normal finish, not a timeout.
          r_timeout_err <= w_wd_exp && !eng_done;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_req_ready = '0;
    if (r_state == S_ISSUE && eng_ready) w_req_ready[r_eng_src] = 1'b1;
  end

  assign req_ready   = w_req_ready;
  assign eng_valid   = (r_state == S_ISSUE);
  assign eng_data    = r_eng_data;
  assign eng_src     = r_eng_src;
  assign busy        = (r_state != S_IDLE);
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_tcp_event_arbiter.sv
// Directed self-checking bench for tcp_event_arbiter (NUM_REQ=4, TIMEOUT_CYC=8).
module tb_tcp_event_arbiter;

  localparam int NUM_REQ     = 4;
  localparam int DATA_W      = 32;
  localparam int TIMEOUT_CYC = 8;

  logic                       clk = 1'b0;
  logic                       rst;
  logic [NUM_REQ-1:0]         req_valid;
  logic [NUM_REQ*DATA_W-1:0]  req_data;
  logic [NUM_REQ-1:0]         req_rst;
  logic [NUM_REQ-1:0]         req_ready;
  logic                       eng_valid;
  logic [DATA_W-1:0]          eng_data;
  logic [1:0]                 eng_src;
  logic                       eng_ready;
  logic                       eng_done;
  logic                       busy;
  logic                       timeout_err;

  logic [DATA_W-1:0] src_data [NUM_REQ];

  int n_cmp = 0;
  int n_bad = 0;

  tcp_event_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .DATA_W     (DATA_W),
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_rst    (req_rst),
    .req_ready  (req_ready),
    .eng_valid  (eng_valid),
    .eng_data   (eng_data),
    .eng_src    (eng_src),
    .eng_ready  (eng_ready),
    .eng_done   (eng_done),
    .busy       (busy),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  always_comb begin
    req_data = '0;
    for (int i = 0; i < NUM_REQ; i++) req_data[i*DATA_W +: DATA_W] = src_data[i];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Called at a falling edge with the arbiter idle; ends at a falling edge with the arbiter idle again.
  task automatic do_event(input string tag, input logic [3:0] mask, input logic [3:0] rmask,
                          input int exp_src, input int done_wait);
    req_valid = mask;
    req_rst   = rmask;
    eng_ready = 1'b1;
    eng_done  = 1'b0;
    #1 check({tag, "_latency"}, 64'(eng_valid), 64'(0));
    @(posedge clk); @(negedge clk);
    check({tag, "_valid"}, 64'(eng_valid), 64'(1));
    check({tag, "_src"},   64'(eng_src),   64'(exp_src));
    check({tag, "_data"},  64'(eng_data),  64'(src_data[exp_src]));
    check({tag, "_ready"}, 64'(req_ready), 64'(4'b0001 << exp_src));
    @(posedge clk); @(negedge clk);
    check({tag, "_wait_valid"}, 64'(eng_valid), 64'(0));
    check({tag, "_wait_ready"}, 64'(req_ready), 64'(0));
    check({tag, "_wait_busy"},  64'(busy),      64'(1));
    repeat (done_wait) @(negedge clk);
    eng_done = 1'b1;
    @(posedge clk); @(negedge clk);
    eng_done = 1'b0;
    check({tag, "_idle_busy"}, 64'(busy), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int pulses;
    int exp_prio;

    src_data[0] = 32'h1111_0000;
    src_data[1] = 32'h2222_0001;
    src_data[2] = 32'h0000_00A5;
    src_data[3] = 32'h4444_0003;
    rst       = 1'b1;
    req_valid = '0;
    req_rst   = '0;
    eng_ready = 1'b0;
    eng_done  = 1'b0;

    // Reset values
    #12;
    check("rst_valid",   64'(eng_valid),   64'(0));
    check("rst_busy",    64'(busy),        64'(0));
    check("rst_ready",   64'(req_ready),   64'(0));
    check("rst_src",     64'(eng_src),     64'(0));
    check("rst_data",    64'(eng_data),    64'(0));
    check("rst_timeout", 64'(timeout_err), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single source 2 with payload 0xA5; rr_ptr becomes 3
    do_event("single", 4'b0100, 4'b0000, 2, 0);

    // Wrap from rr_ptr=3: source 0 then source 1; rr_ptr becomes 2
    do_event("wrap0", 4'b0011, 4'b0000, 0, 0);
    do_event("wrap1", 4'b0011, 4'b0000, 1, 0);
    req_valid = '0;

    // Reset in the middle of ISSUE (source 2 granted from rr_ptr=2)
    req_valid = 4'b1111;
    eng_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    check("midrst_pre_valid", 64'(eng_valid), 64'(1));
    check("midrst_pre_src",   64'(eng_src),   64'(2));
    eng_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", 64'(eng_valid), 64'(0));
    check("midrst_busy",  64'(busy),      64'(0));
    check("midrst_ready", 64'(req_ready), 64'(0));
    @(negedge clk);
    req_valid = '0;
    eng_ready = 1'b0;
    rst       = 1'b0;
    @(negedge clk);
    check("midrst_src",  64'(eng_src),  64'(0));
    check("midrst_data", 64'(eng_data), 64'(0));

    // Fairness from rr_ptr=0 with all sources pending: 0,1,2,3,0
    do_event("fair0", 4'b1111, 4'b0000, 0, 1);
    do_event("fair1", 4'b1111, 4'b0000, 1, 1);
    do_event("fair2", 4'b1111, 4'b0000, 2, 1);
    do_event("fair3", 4'b1111, 4'b0000, 3, 1);
    do_event("fair4", 4'b1111, 4'b0000, 0, 1);
    req_valid = '0;

    // Backpressure: source 1 (rr_ptr=1) stalled for 10 cycles
    req_valid = 4'b1111;
    eng_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      check("bp_valid", 64'(eng_valid), 64'(1));
      check("bp_src",   64'(eng_src),   64'(1));
      check("bp_data",  64'(eng_data),  64'(src_data[1]));
      check("bp_ready", 64'(req_ready), 64'(0));
      @(negedge clk);
    end
    eng_ready = 1'b1;
    #1 check("bp_release_ready", 64'(req_ready), 64'(4'b0010));
    req_valid = '0;
    @(posedge clk); @(negedge clk);
    eng_done = 1'b1;
    @(posedge clk); @(negedge clk);
    eng_done = 1'b0;
    check("bp_idle", 64'(busy), 64'(0));

    // Watchdog: source 2 (rr_ptr=2), engine never completes
    req_valid = 4'b0100;
    eng_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    check("wd_grant_ready", 64'(req_ready), 64'(4'b0100));
    req_valid = '0;
    @(posedge clk); @(negedge clk);
    pulses = 0;
    check("wd_k0", 64'(timeout_err), 64'(0));
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (timeout_err) pulses++;
      check($sformatf("wd_k%0d", k), 64'(timeout_err), 64'(k == 8));
      if (k == 8) check("wd_released", 64'(busy), 64'(0));
    end
    check("wd_pulse_count", 64'(pulses), 64'(1));
    do_event("wd_next", 4'b1111, 4'b0000, 3, 0);
    req_valid = '0;

    // RST priority from rr_ptr=0
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
`ifdef RST_PRIO_EN
    exp_prio = 3;
`else
    exp_prio = 0;
`endif
    do_event("prio", 4'b1001, 4'b1000, exp_prio, 0);
    req_valid = '0;
    req_rst   = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
